// File: rtl/fuzz_sig_collector.sv
// rtl/fuzz_sig_collector.sv - MISR signature collector for a DUT output bus
//
// Samples the flat y bus for NCYC cycles after a start, compacts it into a
// SIG_W-bit MISR signature, then streams the signature MSB-first in OUT_W
// beats over a valid/ready handshake and pulses done after the last beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides everything
//   start      begin a collection window (only honoured in IDLE)
//   y          observed DUT output bus (Y_W bits)
//   busy       high while collecting or draining
//   sig_valid  signature beat valid
//   sig_data   signature beat (OUT_W bits, MSB-first)
//   sig_last   marks the final beat
//   sig_ready  downstream accepts the current beat
//   done       one-cycle pulse after the last beat is accepted

module fuzz_sig_collector #(
    parameter int              Y_W   = 82,
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF,
    parameter int              NCYC  = 64,
    parameter int              OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Y_W-1:0]   y,
    output logic             busy,
    output logic             sig_valid,
    output logic [OUT_W-1:0] sig_data,
    output logic             sig_last,
    input  logic             sig_ready,
    output logic             done
);

    localparam int NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
    localparam int EXT_W  = NCHUNK * SIG_W;
    localparam int NBEAT  = SIG_W / OUT_W;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    // Sized to hold NCYC itself so the counter never wraps.
    localparam int CNT_W  = $clog2(NCYC + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [EXT_W-1:0]  y_ext;
    logic [SIG_W-1:0]  fold;
    logic [SIG_W-1:0]  misr_next;
    logic [OUT_W-1:0]  beat_data;
    logic              last_beat;

    // Zero padding above Y_W means chunks that are partly beyond the bus
    // contribute only their real bits to the fold.
    assign y_ext = EXT_W'(y);

    always_comb begin
        fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ y_ext[i*SIG_W +: SIG_W];
        end
    end

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ fold;

    assign last_beat = (beat_q == BEAT_W'(NBEAT - 1));

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < NBEAT; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                beat_data = sig_q[SIG_W-1-k*OUT_W -: OUT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    beat_d  = '0;
                end
            end
            ST_COLLECT: begin
                sig_d = misr_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NCYC - 1)) begin
                    state_d = ST_DRAIN;
                    beat_d  = '0;
                end
            end
            ST_DRAIN: begin
                // sig is frozen here; only the beat pointer advances.
                if (sig_ready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Stream outputs decode registered state only, so y never reaches them.
    assign sig_valid = (state_q == ST_DRAIN);
    assign sig_last  = sig_valid && last_beat;
    assign sig_data  = sig_valid ? beat_data : '0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fuzz_sig_collector.sv
// tb/tb_fuzz_sig_collector.sv - directed self-checking bench for fuzz_sig_collector

module tb_fuzz_sig_collector;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, start_b;
    logic [81:0] y_a, y_b;
    logic        busy_a, busy_b;
    logic        sig_valid_a, sig_valid_b;
    logic [7:0]  sig_data_a, sig_data_b;
    logic        sig_last_a, sig_last_b;
    logic        sig_ready_a, sig_ready_b;
    logic        done_a, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fuzz_sig_collector #(.NCYC(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .y(y_a), .busy(busy_a),
        .sig_valid(sig_valid_a), .sig_data(sig_data_a), .sig_last(sig_last_a),
        .sig_ready(sig_ready_a), .done(done_a)
    );

    fuzz_sig_collector dut_b (
        .clk(clk), .rst(rst), .start(start_b), .y(y_b), .busy(busy_b),
        .sig_valid(sig_valid_b), .sig_data(sig_data_b), .sig_last(sig_last_b),
        .sig_ready(sig_ready_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fold(input logic [81:0] yv);
        logic [95:0] e;
        e = {14'b0, yv};
        return e[31:0] ^ e[63:32] ^ e[95:64];
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [81:0] yv);
        return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0)) ^ fold(yv);
    endfunction

    function automatic logic [81:0] ypat(input int c);
        logic [17:0] hi;
        logic [31:0] mid, lo;
        hi  = 18'(c * 7 + 1);
        mid = 32'(c) * 32'h9E3779B9;
        lo  = 32'hA5A55A5A ^ 32'(c << 3);
        return {hi, mid, lo};
    endfunction

    // Drives one window from the cycle after start was accepted until done
    // is seen (or the cycle budget runs out). expv is the bench's own model.
    task automatic run_window(input int which, input int ncyc, input logic [81:0] ybase,
                              input bit vary, input int bp_beat, input int bp_len,
                              input bit glitch, output logic [31:0] got,
                              output logic [31:0] expv, output int beats,
                              output int dones, output int stalls);
        logic [81:0] yv;
        logic [7:0]  d;
        logic [31:0] shifted;
        bit          r, v, l;
        expv = SEED; got = '0; beats = 0; dones = 0; stalls = 0;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            yv = vary ? ypat(c) : ybase;
            if (c < ncyc) expv = misr_step(expv, yv);
            r = !(beats == bp_beat && stalls < bp_len);
            v = which ? sig_valid_b : sig_valid_a;
            d = which ? sig_data_b : sig_data_a;
            l = which ? sig_last_b : sig_last_a;
            if (which) begin
                y_b = yv; sig_ready_b = r;
                start_b = glitch && (c == 5 || (v && beats == 1));
            end else begin
                y_a = yv; sig_ready_a = r;
                start_a = glitch && (c == 5 || (v && beats == 1));
            end
            if (v && r) begin
                got = {got[23:0], d};
                chk("last_flag", {31'b0, l}, {31'b0, (beats == 3)});
                beats++;
            end else if (v) begin
                stalls++;
                shifted = expv << (8 * beats);
                chk("stall_hold", {24'b0, d}, {24'b0, shifted[31:24]});
            end
            tick();
            if (which ? done_b : done_a) dones++;
        end
        if (which) start_b = 1'b0; else start_a = 1'b0;
    endtask

    logic [31:0] got, expv;
    int beats, dones, stalls, stray;

    initial begin
        rst = 1'b1;
        start_a = 0; start_b = 0; y_a = '0; y_b = '0;
        sig_ready_a = 0; sig_ready_b = 0;
        tick(); tick();

        chk("rst_busy_a",  {31'b0, busy_a}, 32'd0);
        chk("rst_valid_a", {31'b0, sig_valid_a}, 32'd0);
        chk("rst_data_a",  {24'b0, sig_data_a}, 32'd0);
        chk("rst_last_a",  {31'b0, sig_last_a}, 32'd0);
        chk("rst_done_a",  {31'b0, done_a}, 32'd0);
        chk("rst_busy_b",  {31'b0, busy_b}, 32'd0);
        chk("rst_valid_b", {31'b0, sig_valid_b}, 32'd0);
        chk("rst_done_b",  {31'b0, done_b}, 32'd0);
        rst = 1'b0;
        tick();

        // NCYC=1, y=0: exact cycle-by-cycle timing.
        y_a = '0; sig_ready_a = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t1_busy_collect", {31'b0, busy_a}, 32'd1);
        chk("t1_valid_collect", {31'b0, sig_valid_a}, 32'd0);
        tick();
        chk("t1_b0_valid", {31'b0, sig_valid_a}, 32'd1);
        chk("t1_b0_data", {24'b0, sig_data_a}, 32'hFB);
        chk("t1_b0_last", {31'b0, sig_last_a}, 32'd0);
        tick();
        chk("t1_b1_data", {24'b0, sig_data_a}, 32'h3E);
        tick();
        chk("t1_b2_data", {24'b0, sig_data_a}, 32'hE2);
        chk("t1_b2_last", {31'b0, sig_last_a}, 32'd0);
        tick();
        chk("t1_b3_data", {24'b0, sig_data_a}, 32'h49);
        chk("t1_b3_last", {31'b0, sig_last_a}, 32'd1);
        tick();
        chk("t1_done", {31'b0, done_a}, 32'd1);
        chk("t1_valid_off", {31'b0, sig_valid_a}, 32'd0);
        chk("t1_busy_off", {31'b0, busy_a}, 32'd0);
        tick();
        chk("t1_done_pulse", {31'b0, done_a}, 32'd0);

        // Chunk folding: bit 0 and bit 32 alias; bit 81 lands on bit 17.
        start_a = 1'b1; y_a = 82'h1; tick(); start_a = 1'b0;
        run_window(0, 1, 82'h1, 0, -1, 0, 0, got, expv, beats, dones, stalls);
        chk("fold_bit0_sig", got, 32'hFB3EE248);
        chk("fold_bit0_beats", beats, 4);
        chk("fold_bit0_done", dones, 1);
        tick();

        start_a = 1'b1; y_a = 82'h1 << 32; tick(); start_a = 1'b0;
        run_window(0, 1, 82'h1 << 32, 0, -1, 0, 0, got, expv, beats, dones, stalls);
        chk("fold_bit32_sig", got, 32'hFB3EE248);
        tick();

        start_a = 1'b1; y_a = 82'h1 << 81; tick(); start_a = 1'b0;
        run_window(0, 1, 82'h1 << 81, 0, -1, 0, 0, got, expv, beats, dones, stalls);
        chk("fold_bit81_sig", got, 32'hFB3CE249);
        tick();

        // Default window with 3 stall cycles on beat 1.
        start_b = 1'b1; y_b = ypat(0); tick(); start_b = 1'b0;
        run_window(1, 64, '0, 1, 1, 3, 0, got, expv, beats, dones, stalls);
        chk("bp_sig", got, expv);
        chk("bp_beats", beats, 4);
        chk("bp_stalls", stalls, 3);
        chk("bp_done", dones, 1);
        tick();
        chk("bp_done_pulse", {31'b0, done_b}, 32'd0);

        // Stray starts during COLLECT and DRAIN are ignored.
        start_b = 1'b1; y_b = ypat(0); tick(); start_b = 1'b0;
        run_window(1, 64, '0, 1, -1, 0, 1, got, expv, beats, dones, stalls);
        chk("glitch_sig", got, expv);
        chk("glitch_beats", beats, 4);
        chk("glitch_done", dones, 1);

        // start on the done cycle opens a fresh window from SEED.
        start_b = 1'b1; y_b = ypat(0); tick(); start_b = 1'b0;
        chk("b2b_done_low", {31'b0, done_b}, 32'd0);
        chk("b2b_busy", {31'b0, busy_b}, 32'd1);
        run_window(1, 64, '0, 1, -1, 0, 0, got, expv, beats, dones, stalls);
        chk("b2b_sig", got, expv);
        chk("b2b_done", dones, 1);
        tick();

        // Reset on the edge that would take sample 10 aborts the window.
        start_b = 1'b1; y_b = ypat(0); tick(); start_b = 1'b0;
        for (int c = 0; c < 9; c++) begin
            y_b = ypat(c); tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", {31'b0, busy_b}, 32'd0);
        stray = 0;
        sig_ready_b = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (sig_valid_b || done_b) stray++;
            tick();
        end
        chk("abort_no_output", stray, 0);

        start_b = 1'b1; y_b = ypat(0); tick(); start_b = 1'b0;
        run_window(1, 64, '0, 1, -1, 0, 0, got, expv, beats, dones, stalls);
        chk("after_abort_sig", got, expv);
        chk("after_abort_done", dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
